// File: rtl/tilemap_fetch.sv
// tilemap_fetch: dual-layer scrolled tilemap/ROM fetch sequencer feeding a CUS43-style tile generator.
module tilemap_fetch (
    input  logic        CLK_6M,
    input  logic        RESET,
    input  logic        LINE_START,
    input  logic [7:0]  VPOS,
    input  logic        CPU_WR,
    input  logic [2:0]  CPU_A,
    input  logic [7:0]  CPU_D,
    output logic [11:0] VA,
    input  logic [15:0] VD,
    output logic [14:0] GA,
    input  logic [11:0] GD,
    output logic [7:0]  MDI,
    output logic [11:0] GDI,
    output logic        CLK_2H,
    output logic        HA2,
    output logic        HB2
);
    logic [8:0]       hcount_q, hcount_d;
    logic [1:0][8:0]  sx_sh_q, sx_sh_d;
    logic [1:0][7:0]  sy_sh_q, sy_sh_d, sy_q, sy_d;
    logic [1:0][6:0]  sx_q, sx_d;
    logic [11:0]      va_q, va_d;
    logic [14:0]      ga_q, ga_d;
    logic [15:0]      vd_a_q, vd_a_d, vd_b_q, vd_b_d;
    logic [3:0]       sub_a_q, sub_a_d, sub_b_q, sub_b_d;
    logic [19:0]      out_a_q, out_a_d, out_b_q, out_b_d;
    logic             sel;
    logic [6:0]       t;
    logic [7:0]       y;
    logic             unused_sx_lsb;

    // hcount[1] picks the layer whose tilemap address is issued this half-group
    assign sel = hcount_q[1];
    assign t = hcount_q[8:2] + 7'd2 + sx_q[sel];
    assign y = VPOS + sy_q[sel];
    assign unused_sx_lsb = ^{sx_sh_q[1][1:0], sx_sh_q[0][1:0]};

    always_comb begin
        hcount_d = LINE_START ? 9'd0 : hcount_q + 9'd1;
        sx_sh_d = sx_sh_q;
        sy_sh_d = sy_sh_q;
        if (CPU_WR && CPU_A[1:0] == 2'd0) sx_sh_d[CPU_A[2]][7:0] = CPU_D;
        if (CPU_WR && CPU_A[1:0] == 2'd1) sx_sh_d[CPU_A[2]][8] = CPU_D[0];
        if (CPU_WR && CPU_A[1:0] == 2'd2) sy_sh_d[CPU_A[2]] = CPU_D;
        sx_d = LINE_START ? {sx_sh_q[1][8:2], sx_sh_q[0][8:2]} : sx_q;
        sy_d = LINE_START ? sy_sh_q : sy_q;
        va_d = va_q;
        ga_d = ga_q;
        vd_a_d = vd_a_q;
        vd_b_d = vd_b_q;
        sub_a_d = sub_a_q;
        sub_b_d = sub_b_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        // a line start abandons whatever the current phase would have done
        if (!LINE_START) begin
            unique case (hcount_q[1:0])
                2'd0: begin
                    va_d = {sel, y[7:3], t[6:1]};
                    sub_a_d = {y[2:0], t[0]};
                    ga_d = {vd_b_q[10:0], sub_b_q};
                end
                2'd1: begin
                    vd_a_d = VD;
                    out_b_d = {vd_b_q[15:8], GD};
                end
                2'd2: begin
                    va_d = {sel, y[7:3], t[6:1]};
                    sub_b_d = {y[2:0], t[0]};
                    ga_d = {vd_a_q[10:0], sub_a_q};
                end
                2'd3: begin
                    vd_b_d = VD;
                    out_a_d = {vd_a_q[15:8], GD};
                end
            endcase
        end
    end

    always_ff @(posedge CLK_6M or posedge RESET) begin
        if (RESET) begin
            hcount_q <= '0;
            sx_sh_q <= '0;
            sy_sh_q <= '0;
            sx_q <= '0;
            sy_q <= '0;
            va_q <= '0;
            ga_q <= '0;
            vd_a_q <= '0;
            vd_b_q <= '0;
            sub_a_q <= '0;
            sub_b_q <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            sx_sh_q <= sx_sh_d;
            sy_sh_q <= sy_sh_d;
            sx_q <= sx_d;
            sy_q <= sy_d;
            va_q <= va_d;
            ga_q <= ga_d;
            vd_a_q <= vd_a_d;
            vd_b_q <= vd_b_d;
            sub_a_q <= sub_a_d;
            sub_b_q <= sub_b_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    assign VA = va_q;
    assign GA = ga_q;
    assign CLK_2H = hcount_q[1];
    assign HA2 = hcount_q[1:0] == 2'd1;
    assign HB2 = hcount_q[1:0] == 2'd3;
    assign MDI = CLK_2H ? out_b_q[19:12] : out_a_q[19:12];
    assign GDI = CLK_2H ? out_b_q[11:0] : out_a_q[11:0];
endmodule

// File: tb/tb_tilemap_fetch.sv
// tb_tilemap_fetch: randomized self-checking bench for tilemap_fetch against a transaction-level fetch model.
module tb_tilemap_fetch;
    logic        CLK_6M = 0;
    logic        RESET, LINE_START, CPU_WR;
    logic [7:0]  VPOS, CPU_D;
    logic [2:0]  CPU_A;
    logic [11:0] VA;
    logic [15:0] VD;
    logic [14:0] GA;
    logic [11:0] GD;
    logic [7:0]  MDI;
    logic [11:0] GDI;
    logic        CLK_2H, HA2, HB2;

    logic [15:0] vram [4096];
    logic [11:0] rom [32768];
    int checks = 0, errors = 0;
    int hc = 0, run = 0;
    int m_sx_sh [2], m_sx [2], m_sy_sh [2], m_sy [2];

    tilemap_fetch dut (
        .CLK_6M(CLK_6M), .RESET(RESET), .LINE_START(LINE_START), .VPOS(VPOS),
        .CPU_WR(CPU_WR), .CPU_A(CPU_A), .CPU_D(CPU_D), .VA(VA), .VD(VD), .GA(GA), .GD(GD),
        .MDI(MDI), .GDI(GDI), .CLK_2H(CLK_2H), .HA2(HA2), .HB2(HB2)
    );

    always #5 CLK_6M = ~CLK_6M;
    assign VD = vram[VA];
    assign GD = rom[GA];

    function automatic int m_t(int l, int g);
        return (g + 2 + m_sx[l] / 4) % 128;
    endfunction
    function automatic int m_y(int l);
        return (int'(VPOS) + m_sy[l]) % 256;
    endfunction
    function automatic int m_va(int l, int g);
        return l * 2048 + (m_y(l) / 8) * 64 + m_t(l, g) / 2;
    endfunction
    function automatic int m_ga(int l, int g);
        int d;
        d = int'(vram[m_va(l, g)]);
        return (((d / 256) % 8) * 256 + d % 256) * 16 + (m_y(l) % 8) * 2 + m_t(l, g) % 2;
    endfunction

    task automatic model_reset();
        hc = 0;
        run = 0;
        for (int i = 0; i < 2; i++) begin
            m_sx_sh[i] = 0; m_sx[i] = 0; m_sy_sh[i] = 0; m_sy[i] = 0;
        end
    endtask

    task automatic tick(input bit ls, input bit wr, input int a, input int d);
        int l;
        LINE_START = ls;
        CPU_WR = wr;
        CPU_A = 3'(a);
        CPU_D = 8'(d);
        @(posedge CLK_6M);
        if (ls) begin
            hc = 0;
            run = 0;
            m_sx = m_sx_sh;
            m_sy = m_sy_sh;
        end else begin
            hc = (hc + 1) % 512;
            if (run < 100000) run++;
        end
        l = (a / 4) % 2;
        if (wr && a % 4 == 0) m_sx_sh[l] = (m_sx_sh[l] / 256) * 256 + d;
        if (wr && a % 4 == 1) m_sx_sh[l] = (m_sx_sh[l] % 256) + (d % 2) * 256;
        if (wr && a % 4 == 2) m_sy_sh[l] = d;
        @(negedge CLK_6M);
        LINE_START = 0;
        CPU_WR = 0;
    endtask

    task automatic test_reset();
        checks++;
        if ({VA, GA, MDI, GDI, CLK_2H, HA2, HB2} !== '0) begin
            errors++;
            $display("FAIL reset_initial outputs=%h expected 0", {VA, GA, MDI, GDI, CLK_2H, HA2, HB2});
        end
        @(negedge CLK_6M);
        RESET = 0;
        for (int i = 0; i < 45; i++) tick(0, 0, 0, 0);
        #2 RESET = 1;
        #1;
        checks++;
        if ({VA, GA, MDI, GDI, CLK_2H, HA2, HB2} !== '0) begin
            errors++;
            $display("FAIL reset_midline outputs=%h expected 0", {VA, GA, MDI, GDI, CLK_2H, HA2, HB2});
        end
        model_reset();
        @(negedge CLK_6M);
        RESET = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (HA2 !== (hc % 4 == 1) || HB2 !== (hc % 4 == 3) || CLK_2H !== (hc % 4 >= 2)) begin
                errors++;
                $display("FAIL reset_cadence hc=%0d ha2=%b hb2=%b clk2h=%b expected %b %b %b", hc,
                         HA2, HB2, CLK_2H, hc % 4 == 1, hc % 4 == 3, hc % 4 >= 2);
            end
        end
    endtask

    task automatic test_zero_scroll();
        vram[12'h101] = 16'hA35C;
        rom[15'h35CA] = 12'h9F3;
        VPOS = 8'h25;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 0);
            if (hc == 1) begin
                checks++;
                if (VA !== 12'h101) begin errors++; $display("FAIL zero_va_a VA=%h expected 101", VA); end
            end
            if (hc == 3) begin
                checks++;
                if (VA !== 12'h901 || GA !== 15'h35CA) begin
                    errors++; $display("FAIL zero_va_b_ga VA=%h GA=%h expected 901 35ca", VA, GA);
                end
            end
            if (hc == 4 || hc == 5) begin
                checks++;
                if (MDI !== 8'hA3 || GDI !== 12'h9F3 || CLK_2H !== 1'b0 || HA2 !== (hc == 5)) begin
                    errors++;
                    $display("FAIL zero_out_a hc=%0d MDI=%h GDI=%h clk2h=%b ha2=%b expected a3 9f3 0 %b",
                             hc, MDI, GDI, CLK_2H, HA2, hc == 5);
                end
            end
        end
    endtask

    task automatic test_scroll_shadow();
        VPOS = 8'h25;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0);
        tick(0, 1, 0, 8'hFC);
        tick(0, 1, 1, 8'h01);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 0);
            if (hc % 4 == 1) begin
                checks++;
                if (VA !== 12'(m_va(0, hc / 4)) || int'(VA[5:0]) != ((hc / 4 + 2) % 128) / 2) begin
                    errors++; $display("FAIL shadow_hold VA=%h expected %h", VA, 12'(m_va(0, hc / 4)));
                end
            end
        end
        tick(1, 0, 0, 0);
        for (int i = 0; i < 530; i++) begin
            tick(0, 0, 0, 0);
            if (run >= 8 && (hc == 1 || hc == 505 || hc == 509)) begin
                checks++;
                if (int'(VA[5:0]) != (hc == 505 ? 63 : 0) || VA[11] !== 1'b0) begin
                    errors++; $display("FAIL scroll_col hc=%0d VA=%h expected col %0d", hc, VA, hc == 505 ? 63 : 0);
                end
            end
            if (run >= 8 && hc == 3) begin
                checks++;
                if (GA[0] !== 1'b1 || GA !== 15'(m_ga(0, 0))) begin
                    errors++; $display("FAIL scroll_half GA=%h expected %h", GA, 15'(m_ga(0, 0)));
                end
            end
        end
    endtask

    task automatic test_y_scroll();
        tick(0, 1, 6, 8'hF0);
        VPOS = 8'h20;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 0);
            if (hc % 4 == 3) begin
                checks++;
                if (VA[11:6] !== 6'b100010 || VA !== 12'(m_va(1, hc / 4))) begin
                    errors++; $display("FAIL y_scroll_va VA=%h expected %h", VA, 12'(m_va(1, hc / 4)));
                end
            end
            if (hc % 4 == 1 && run >= 5) begin
                checks++;
                if (GA[3:1] !== 3'd0) begin errors++; $display("FAIL y_scroll_pixrow GA=%h expected pixrow 0", GA); end
            end
        end
    endtask

    task automatic test_midgroup_linestart();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        checks++;
        if (HA2 !== 1'b0 || HB2 !== 1'b0 || CLK_2H !== 1'b0) begin
            errors++; $display("FAIL midgroup_restart ha2=%b hb2=%b clk2h=%b expected 0 0 0", HA2, HB2, CLK_2H);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (HA2 !== (i % 4 == 0) || HB2 !== (i % 4 == 2)) begin
                errors++;
                $display("FAIL midgroup_cadence step=%0d ha2=%b hb2=%b expected %b %b", i, HA2, HB2, i % 4 == 0, i % 4 == 2);
            end
        end
    endtask

    task automatic test_random_fetch();
        int g, p, pg, el, len;
        int ev, eg, em, ed;
        for (int line = 0; line < 7; line++) begin
            VPOS = 8'($urandom);
            tick(1, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 255));
            len = $urandom_range(20, 560);
            for (int c = 0; c < len; c++) begin
                tick(0, $urandom_range(0, 7) == 0, $urandom_range(0, 7), $urandom_range(0, 255));
                g = hc / 4; p = hc % 4; pg = (g + 127) % 128;
                checks++;
                if (HA2 !== (p == 1) || HB2 !== (p == 3) || CLK_2H !== (p >= 2)) begin
                    errors++; $display("FAIL rand_strobe hc=%0d ha2=%b hb2=%b clk2h=%b", hc, HA2, HB2, CLK_2H);
                end
                if (run >= 8) begin
                    ev = (p == 1 || p == 2) ? m_va(0, g) : (p == 3) ? m_va(1, g) : m_va(1, pg);
                    eg = (p == 3) ? m_ga(0, g) : (p == 0) ? m_ga(0, pg) : m_ga(1, pg);
                    el = p < 2 ? 0 : 1;
                    em = int'(vram[m_va(el, pg)]) / 256;
                    ed = int'(rom[m_ga(el, pg)]);
                    checks++;
                    if (VA !== 12'(ev)) begin errors++; $display("FAIL rand_va hc=%0d VA=%h expected %h", hc, VA, 12'(ev)); end
                    checks++;
                    if (GA !== 15'(eg)) begin errors++; $display("FAIL rand_ga hc=%0d GA=%h expected %h", hc, GA, 15'(eg)); end
                    checks++;
                    if (MDI !== 8'(em) || GDI !== 12'(ed)) begin
                        errors++; $display("FAIL rand_out hc=%0d MDI=%h GDI=%h expected %h %h", hc, MDI, GDI, 8'(em), 12'(ed));
                    end
                end
            end
        end
    endtask

    initial begin
        RESET = 1; LINE_START = 0; CPU_WR = 0; CPU_A = 0; CPU_D = 0; VPOS = 0;
        for (int i = 0; i < 4096; i++) vram[i] = 16'($urandom);
        for (int i = 0; i < 32768; i++) rom[i] = 12'($urandom);
        model_reset();
        #1;
        test_reset();
        test_zero_scroll();
        test_scroll_shadow();
        test_y_scroll();
        test_midgroup_linestart();
        test_random_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
